// File: rtl/memctrl.sv
// Byte-serial memory controller: arbitrates LSB and fetch requests onto an 8-bit RAM,
// splitting 1/2/4-byte accesses into byte cycles and assembling read data little-endian.
module memctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        go_work,
  input  logic        l_or_s,
  input  logic [2:0]  width,
  input  logic [31:0] address,
  input  logic [31:0] value_store,
  output logic        received,
  output logic        has_result,
  output logic [31:0] value_load,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        flush_in
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic [2:0]  len_reg;
  logic [31:0] store_reg;
  logic [31:0] buf_reg;
  logic [31:0] buf_next;
  logic        wr_reg;
  logic        rd_vld_reg;
  logic [1:0]  rd_lane_reg;
  logic [1:0]  lane_now;
  logic        reading;
  logic        io_stall;

  assign reading  = (state_reg == LOAD) || (state_reg == FETCH);
  assign io_stall = (mem_a[17:16] == 2'b11) && io_buffer_full;
  assign mem_wr   = wr_reg && rdy_in && !io_stall;
  assign lane_now = (idx_reg < len_reg) ? idx_reg[1:0] : 2'(len_reg - 3'd1);

  // mem_din always belongs to whichever lane was on mem_a last cycle, paused or not,
  // so capture is tracked per cycle rather than per ready step.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign buf_next[8*gi +: 8] = (rd_vld_reg && rd_lane_reg == 2'(gi)) ? mem_din
                                                                         : buf_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg   <= IDLE;
      idx_reg     <= 3'd0;
      len_reg     <= 3'd0;
      store_reg   <= 32'd0;
      buf_reg     <= 32'd0;
      wr_reg      <= 1'b0;
      rd_vld_reg  <= 1'b0;
      rd_lane_reg <= 2'd0;
      mem_a       <= 32'd0;
      mem_dout    <= 8'd0;
      received    <= 1'b0;
      has_result  <= 1'b0;
      value_load  <= 32'd0;
      if_done     <= 1'b0;
      if_inst     <= 32'd0;
    end else begin
      received    <= 1'b0;
      has_result  <= 1'b0;
      if_done     <= 1'b0;
      rd_vld_reg  <= reading;
      rd_lane_reg <= lane_now;
      if (reading) begin
        buf_reg <= buf_next;
      end
      if (rdy_in) begin
        case (state_reg)
          IDLE: begin
            if (go_work && !received) begin
              received <= 1'b1;
              mem_a    <= address;
              idx_reg  <= 3'd0;
              buf_reg  <= 32'd0;
              len_reg  <= (width == 3'd1) ? 3'd1 : (width == 3'd2) ? 3'd2 : 3'd4;
              if (l_or_s) begin
                state_reg <= STORE;
                wr_reg    <= 1'b1;
                mem_dout  <= value_store[7:0];
                store_reg <= {8'd0, value_store[31:8]};
              end else begin
                state_reg <= LOAD;
              end
            end else if (if_req && !flush_in) begin
              state_reg <= FETCH;
              mem_a     <= if_addr;
              idx_reg   <= 3'd0;
              buf_reg   <= 32'd0;
              len_reg   <= 3'd4;
            end
          end
          LOAD, FETCH: begin
            if (state_reg == FETCH && flush_in) begin
              state_reg <= IDLE;
            end else if (idx_reg == len_reg) begin
              state_reg <= IDLE;
              if (state_reg == LOAD) begin
                has_result <= 1'b1;
                value_load <= buf_next;
              end else begin
                if_done <= 1'b1;
                if_inst <= buf_next;
              end
            end else begin
              idx_reg <= idx_reg + 3'd1;
              if (idx_reg < len_reg - 3'd1) begin
                mem_a <= mem_a + 32'd1;
              end
            end
          end
          STORE: begin
            if (!io_stall) begin
              if (idx_reg == len_reg - 3'd1) begin
                state_reg <= IDLE;
                wr_reg    <= 1'b0;
              end else begin
                idx_reg   <= idx_reg + 3'd1;
                mem_a     <= mem_a + 32'd1;
                mem_dout  <= store_reg[7:0];
                store_reg <= {8'd0, store_reg[31:8]};
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// Testbench for memctrl: directed scenarios plus randomized transactions checked against
// a byte-array RAM image and a cycle-step timeline derived from the access rules.
module tb_memctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        go_work;
  logic        l_or_s;
  logic [2:0]  width;
  logic [31:0] address;
  logic [31:0] value_store;
  logic        received;
  logic        has_result;
  logic [31:0] value_load;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        flush_in;

  logic [7:0] ram    [0:262143];
  logic [7:0] shadow [0:262143];
  int n_cmp = 0;
  int n_err = 0;

  memctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .go_work(go_work), .l_or_s(l_or_s), .width(width), .address(address),
    .value_store(value_store), .received(received), .has_result(has_result),
    .value_load(value_load), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_inst(if_inst), .flush_in(flush_in)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: one-cycle read latency, write on strobe.
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[17:0]] = mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a[17:0]]    = v;
    shadow[a[17:0]] = v;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mem_a"},      mem_a, 32'd0);
    chk({pfx, "_mem_dout"},   32'(mem_dout), 32'd0);
    chk({pfx, "_mem_wr"},     32'(mem_wr), 32'd0);
    chk({pfx, "_received"},   32'(received), 32'd0);
    chk({pfx, "_has_result"}, 32'(has_result), 32'd0);
    chk({pfx, "_value_load"}, value_load, 32'd0);
    chk({pfx, "_if_done"},    32'(if_done), 32'd0);
    chk({pfx, "_if_inst"},    if_inst, 32'd0);
  endtask

  // kind: 0 load, 1 store, 2 fetch. Pause covers cycles [p_at, p_at+p_len);
  // io_buffer_full is high for cycles 1..s_len. s counts completed byte steps.
  task automatic xact(input int kind, input logic [2:0] w, input logic [31:0] a,
                      input logic [31:0] d, input int p_at, input int p_len, input int s_len);
    int n;
    int s;
    logic [31:0] ak;
    logic [31:0] exp_v;
    bit done;
    bit stall;
    bit pulse;
    n = (kind == 2 || !(w == 3'd1 || w == 3'd2)) ? 4 : int'(w);
    exp_v = 32'd0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      exp_v = exp_v | ({24'd0, shadow[ak[17:0]]} << (8 * k));
    end
    $display("xact kind=%0d width=%0d addr=%08h data=%08h pause=%0d+%0d io_full=%0d",
             kind, w, a, d, p_at, p_len, s_len);
    flush_in = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
    if (kind == 2) begin
      if_req = 1'b1;
      if_addr = a;
    end else begin
      go_work = 1'b1;
      l_or_s = (kind == 1);
      width = w;
      address = a;
      value_store = d;
    end
    s = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      cyc();
      if (c == 1) begin
        go_work = 1'b0;
        if (kind == 2) if_req = 1'b0;
        address = $urandom;
        value_store = $urandom;
        width = 3'($urandom);
        l_or_s = 1'($urandom);
        if (kind == 2) if_addr = $urandom;
      end
      rdy_in = (c >= p_at && c < p_at + p_len) ? 1'b0 : 1'b1;
      io_buffer_full = (c <= s_len);
      if (kind != 2) flush_in = 1'($urandom);
      #1;
      chk("received", 32'(received), 32'(kind != 2 && c == 1));
      if (kind == 1) begin
        chk("st_has_result", 32'(has_result), 32'd0);
        chk("st_if_done", 32'(if_done), 32'd0);
        if (s < n) begin
          ak = a + 32'(s);
          stall = io_buffer_full && (ak[17:16] == 2'b11);
          chk("st_addr", mem_a, ak);
          chk("st_data", 32'(mem_dout), 32'(d[8*s +: 8]));
          chk("st_wr", 32'(mem_wr), 32'(rdy_in && !stall));
          if (rdy_in && !stall) s++;
        end else begin
          chk("st_idle_wr", 32'(mem_wr), 32'd0);
          done = 1'b1;
        end
      end else begin
        ak = a + 32'((s < n) ? s : n - 1);
        chk("rd_addr", mem_a, ak);
        chk("rd_wr", 32'(mem_wr), 32'd0);
        pulse = (s == n + 1);
        chk("has_result", 32'(has_result), 32'(pulse && kind == 0));
        chk("if_done", 32'(if_done), 32'(pulse && kind == 2));
        if (pulse) begin
          if (kind == 0) chk("value_load", value_load, exp_v);
          else           chk("if_inst", if_inst, exp_v);
          done = 1'b1;
        end else if (rdy_in) begin
          s++;
        end
      end
    end
    chk("xact_finished", 32'(done), 32'd1);
    if (kind == 1) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        shadow[ak[17:0]] = d[8*k +: 8];
      end
    end
    flush_in = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] last_a;
    int kind;
    logic [2:0] w;

    for (int i = 0; i < 262144; i++) begin
      ram[i] = 8'($urandom);
      shadow[i] = ram[i];
    end
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; go_work = 1'b0; l_or_s = 1'b0;
    width = 3'd0; address = 32'd0; value_store = 32'd0; if_req = 1'b0; if_addr = 32'd0;
    flush_in = 1'b0;
    repeat (2) cyc();
    #1;
    chk_all_zero("rst");
    rst_in = 1'b1;

    poke(32'h1000, 8'h78); poke(32'h1001, 8'h56); poke(32'h1002, 8'h34); poke(32'h1003, 8'h12);
    xact(0, 3'd4, 32'h1000, 32'd0, 0, 0, 0);
    poke(32'h1800, 8'hF0);
    xact(0, 3'd1, 32'h1800, 32'd0, 0, 0, 0);
    xact(1, 3'd1, 32'h2003, 32'h0000_00AB, 0, 0, 0);
    xact(0, 3'd1, 32'h2003, 32'd0, 0, 0, 0);

    // LSB and fetch both pending: the load must go first, then the fetch.
    poke(32'h0, 8'h13); poke(32'h1, 8'h00); poke(32'h2, 8'h00); poke(32'h3, 8'h00);
    if_req = 1'b1;
    if_addr = 32'h0;
    xact(0, 3'd2, 32'h1000, 32'd0, 0, 0, 0);
    xact(2, 3'd4, 32'h0, 32'd0, 0, 0, 0);

    $display("flush in cycle 2 of fetch, load pending");
    if_req = 1'b1; if_addr = 32'h1000;
    cyc();
    if_req = 1'b0;
    #1;
    chk("fl_addr1", mem_a, 32'h1000);
    cyc();
    flush_in = 1'b1; go_work = 1'b1; l_or_s = 1'b0; width = 3'd1; address = 32'h1800;
    #1;
    chk("fl_addr2", mem_a, 32'h1001);
    cyc();
    flush_in = 1'b0;
    #1;
    chk("fl_if_done", 32'(if_done), 32'd0);
    chk("fl_received", 32'(received), 32'd0);
    xact(0, 3'd1, 32'h1800, 32'd0, 0, 0, 0);

    $display("flush on the completing cycle of a fetch");
    if_req = 1'b1; if_addr = 32'h1000;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) if_req = 1'b0;
      if (c == 5) flush_in = 1'b1;
      #1;
      chk("flc_if_done", 32'(if_done), 32'd0);
    end
    cyc();
    flush_in = 1'b0;
    #1;
    chk("flc_if_done_after", 32'(if_done), 32'd0);
    cyc();
    #1;
    chk("flc_if_done_late", 32'(if_done), 32'd0);

    xact(1, 3'd1, 32'h0003_0000, 32'h0000_0041, 0, 0, 3);
    xact(1, 3'd4, 32'h0003_1000, 32'hCAFE_BABE, 2, 2, 2);
    xact(0, 3'd4, 32'h0003_1000, 32'd0, 0, 0, 0);
    xact(0, 3'd4, 32'h1000, 32'd0, 3, 2, 0);
    xact(0, 3'd4, 32'hFFFF_FFFE, 32'd0, 0, 0, 0);
    xact(1, 3'd2, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 0, 0);
    xact(0, 3'd2, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);

    $display("reset in cycle 3 of a word load");
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd4; address = 32'h1000;
    cyc();
    go_work = 1'b0;
    cyc();
    cyc();
    rst_in = 1'b0;
    #1;
    chk_all_zero("midrst");
    cyc();
    rst_in = 1'b1;
    #1;
    xact(2, 3'd4, 32'h0, 32'd0, 0, 0, 0);

    last_a = 32'h1000;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      w = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 2) == 0) ? last_a : $urandom;
      if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
      xact(kind, w, a, $urandom, $urandom_range(1, 6), $urandom_range(0, 2),
           $urandom_range(0, 3));
      last_a = a;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
